// File: rtl/keypad_scanner_n.sv
// Matrix keypad scanner: one-hot row strobes, tick-rate column sampling, press/release
// debounce and a valid/ack keycode handshake with overrun and multi-key flags.
module keypad_scanner_n #(
    parameter int unsigned ROWS     = 4,
    parameter int unsigned COLS     = 3,
    parameter int unsigned KEY_W    = 4,
    parameter int unsigned TICK_DIV = 50000,
    parameter int unsigned DEBOUNCE = 4
) (
    input  logic             fin,
    input  logic             reset,
    input  logic             enable,
    input  logic [COLS-1:0]  colum,
    input  logic             key_ack,
    output logic [ROWS-1:0]  scan,
    output logic [KEY_W-1:0] keycode,
    output logic             key_valid,
    output logic             key_held,
    output logic             multi,
    output logic             overrun
);

    localparam int unsigned PW = $clog2(TICK_DIV);
    localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int unsigned DW = $clog2(DEBOUNCE + 1);

    typedef enum logic [1:0] {StScan, StDebounce, StHeld} state_e;

    state_e           state_q, state_d;
    logic [COLS-1:0]  col_meta_q, col_sync_q;
    logic [PW-1:0]    pre_q;
    logic [RW-1:0]    row_q, row_d, row_next;
    logic [CW-1:0]    col_q, col_d, col_idx, pub_col;
    logic [DW-1:0]    deb_q, deb_d, rel_q, rel_d;
    logic             multi_q, multi_d;
    logic [KEY_W-1:0] keycode_q, keycode_d;
    logic             valid_q, valid_d;
    logic             overrun_q, overrun_d;
    logic             tick, publish;
    logic [COLS-1:0]  cap_mask;
    int unsigned      n_set;
    int unsigned      code;

    assign tick     = enable && (pre_q == PW'(TICK_DIV - 1));
    assign row_next = (row_q == RW'(ROWS - 1)) ? '0 : row_q + RW'(1);
    assign cap_mask = COLS'(1) << col_q;
    assign code     = 32'(pub_col) * ROWS + 32'(row_q);

    // Count active columns; col_idx is only meaningful when exactly one is set.
    always_comb begin
        n_set   = 0;
        col_idx = '0;
        for (int i = 0; i < int'(COLS); i++) begin
            if (col_sync_q[i]) begin
                n_set   = n_set + 1;
                col_idx = CW'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        deb_d   = deb_q;
        rel_d   = rel_q;
        multi_d = multi_q;
        publish = 1'b0;
        pub_col = col_q;
        if (tick) begin
            unique case (state_q)
                StScan: begin
                    if (n_set == 0) begin
                        multi_d = 1'b0;
                        row_d   = row_next;
                    end else if (n_set == 1) begin
                        col_d   = col_idx;
                        pub_col = col_idx;
                        multi_d = 1'b0;
                        deb_d   = DW'(1);
                        if (DEBOUNCE == 1) begin
                            publish = 1'b1;
                            rel_d   = '0;
                            state_d = StHeld;
                        end else begin
                            state_d = StDebounce;
                        end
                    end else begin
                        multi_d = 1'b1;
                    end
                end
                StDebounce: begin
                    if (col_sync_q == cap_mask) begin
                        deb_d = deb_q + DW'(1);
                        if (deb_q == DW'(DEBOUNCE - 1)) begin
                            publish = 1'b1;
                            rel_d   = '0;
                            state_d = StHeld;
                        end
                    end else begin
                        state_d = StScan;
                    end
                end
                StHeld: begin
                    if (n_set == 0) begin
                        if (rel_q == DW'(DEBOUNCE - 1)) begin
                            rel_d   = '0;
                            row_d   = row_next;
                            state_d = StScan;
                        end else begin
                            rel_d = rel_q + DW'(1);
                        end
                    end else begin
                        rel_d = '0;
                    end
                end
                default: state_d = StScan;
            endcase
        end
    end

    // Publish takes priority over a coincident ack; only an unacked overwrite is an overrun.
    always_comb begin
        keycode_d = keycode_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        if (key_ack) begin
            valid_d   = 1'b0;
            overrun_d = 1'b0;
        end
        if (publish) begin
            keycode_d = KEY_W'(code);
            valid_d   = 1'b1;
            if (valid_q && !key_ack) overrun_d = 1'b1;
        end
    end

    always_ff @(posedge fin) begin
        if (reset) begin
            col_meta_q <= '0;
            col_sync_q <= '0;
            pre_q      <= '0;
            state_q    <= StScan;
            row_q      <= '0;
            col_q      <= '0;
            deb_q      <= '0;
            rel_q      <= '0;
            multi_q    <= 1'b0;
            keycode_q  <= '0;
            valid_q    <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            col_meta_q <= colum;
            col_sync_q <= col_meta_q;
            if (enable) pre_q <= tick ? '0 : pre_q + PW'(1);
            state_q    <= state_d;
            row_q      <= row_d;
            col_q      <= col_d;
            deb_q      <= deb_d;
            rel_q      <= rel_d;
            multi_q    <= multi_d;
            keycode_q  <= keycode_d;
            valid_q    <= valid_d;
            overrun_q  <= overrun_d;
        end
    end

    assign scan      = ROWS'(1) << row_q;
    assign keycode   = keycode_q;
    assign key_valid = valid_q;
    assign key_held  = (state_q == StHeld);
    assign multi     = multi_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_keypad_scanner_n.sv
// Bench for keypad_scanner_n (4x3, TICK_DIV=4, DEBOUNCE=3): directed presses with a
// publication scoreboard plus cycle-timed checks of scan, flags and handshake.
module tb_keypad_scanner_n;

    logic       fin, reset, enable, key_ack;
    logic [2:0] colum;
    logic [3:0] scan, keycode;
    logic       key_valid, key_held, multi, overrun;

    keypad_scanner_n #(
        .ROWS(4), .COLS(3), .KEY_W(4), .TICK_DIV(4), .DEBOUNCE(3)
    ) dut (
        .fin(fin), .reset(reset), .enable(enable), .colum(colum), .key_ack(key_ack),
        .scan(scan), .keycode(keycode), .key_valid(key_valid), .key_held(key_held),
        .multi(multi), .overrun(overrun)
    );

    typedef struct packed {
        logic [3:0] code;
        logic       ovr;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    int         checks = 0;
    int         errors = 0;
    logic       prev_v = 1'b0;
    logic [3:0] prev_k = '0;

    initial fin = 1'b0;
    always #5 fin = ~fin;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge fin);
            #1;
        end
    endtask

    // Returns just after the edge on which scan switches to target.
    task automatic wait_row_entry(input logic [3:0] target);
        logic [3:0] prev;
        bit         hit;
        hit = 0;
        for (int n = 0; n < 200 && !hit; n++) begin
            prev = scan;
            step(1);
            if (prev != target && scan == target) hit = 1;
        end
        check("row_entry_timeout", 32'(hit), 32'd1);
    endtask

    task automatic push(input logic [3:0] code, input logic ovr);
        exp_t e;
        e.code = code;
        e.ovr  = ovr;
        exp_q.push_back(e);
    endtask

    task automatic ack_pulse();
        key_ack = 1'b1;
        step(1);
        key_ack = 1'b0;
    endtask

    // A publication is a rising key_valid or a new keycode while key_valid stays high.
    always @(negedge fin) begin
        if (!reset && key_valid && (!prev_v || keycode != prev_k)) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_publish: got keycode %0d expected none", keycode);
            end else begin
                mon_e = exp_q.pop_front();
                check("pub_keycode", 32'(keycode), 32'(mon_e.code));
                check("pub_overrun", 32'(overrun), 32'(mon_e.ovr));
            end
        end
        prev_v = key_valid;
        prev_k = keycode;
    end

    logic [3:0] idle_seq [5] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};

    initial begin
        reset   = 1'b1;
        enable  = 1'b1;
        colum   = '0;
        key_ack = 1'b0;
        step(2);
        reset = 1'b0;
        check("reset_scan", 32'(scan), 32'h1);
        check("reset_keycode", 32'(keycode), 32'h0);
        check("reset_flags", 32'({key_valid, key_held, multi, overrun}), 32'h0);

        // Idle scanning
        for (int k = 0; k < 5; k++) begin
            step(4);
            check("idle_scan", 32'(scan), 32'(idle_seq[k]));
            check("idle_flags", 32'({key_valid, key_held, multi, overrun}), 32'h0);
        end

        // Press c=1 on row 2 -> keycode 6
        wait_row_entry(4'b0100);
        colum = 3'b010;
        push(4'd6, 1'b0);
        step(11);
        check("press_latency_early", 32'(key_valid), 32'h0);
        step(1);
        check("press_valid", 32'(key_valid), 32'h1);
        check("press_keycode", 32'(keycode), 32'd6);
        check("press_held", 32'(key_held), 32'h1);
        check("press_scan_frozen", 32'(scan), 32'b0100);
        colum = '0;
        step(11);
        check("release_early", 32'(key_held), 32'h1);
        step(1);
        check("release_held", 32'(key_held), 32'h0);
        check("release_scan", 32'(scan), 32'b1000);
        ack_pulse();
        check("ack_valid", 32'(key_valid), 32'h0);

        // Bounce on row 1, c=2 -> keycode 9
        wait_row_entry(4'b0010);
        colum = 3'b100;
        step(4);
        colum = 3'b000;
        step(4);
        check("bounce_scan", 32'(scan), 32'b0010);
        colum = 3'b100;
        push(4'd9, 1'b0);
        step(11);
        check("bounce_no_pub", 32'(key_valid), 32'h0);
        step(1);
        check("bounce_valid", 32'(key_valid), 32'h1);
        colum = '0;
        step(12);
        check("bounce_release", 32'({key_held, scan}), 32'b0_0100);
        ack_pulse();

        // Multi-key on row 3
        wait_row_entry(4'b1000);
        colum = 3'b101;
        step(4);
        check("multi_set", 32'(multi), 32'h1);
        step(8);
        check("multi_frozen", 32'({scan, key_valid}), 32'b1000_0);
        colum = '0;
        step(3);
        check("multi_hold", 32'(multi), 32'h1);
        step(1);
        check("multi_clear", 32'({multi, scan}), 32'b0_0001);

        // Two presses without ack -> overrun
        wait_row_entry(4'b0010);
        colum = 3'b001;
        push(4'd1, 1'b0);
        step(12);
        check("ovr_first", 32'({key_valid, keycode, overrun}), 32'b1_0001_0);
        colum = '0;
        step(12);
        check("ovr_first_rel", 32'(scan), 32'b0100);
        colum = 3'b010;
        push(4'd6, 1'b1);
        step(12);
        check("ovr_second", 32'({key_valid, keycode, overrun}), 32'b1_0110_1);
        colum = '0;
        step(12);
        ack_pulse();
        check("ovr_ack", 32'({key_valid, overrun}), 32'b00);

        // Publish coincident with ack: row 3 c=2 (11), then row 0 c=2 (8)
        colum = 3'b100;
        push(4'd11, 1'b0);
        step(11);
        check("coin_first", 32'({key_valid, keycode}), 32'b1_1011);
        colum = '0;
        step(12);
        check("coin_rel_scan", 32'(scan), 32'b0001);
        colum = 3'b100;
        push(4'd8, 1'b0);
        step(11);
        key_ack = 1'b1;
        step(1);
        key_ack = 1'b0;
        check("coin_pub", 32'({key_valid, keycode, overrun}), 32'b1_1000_0);
        colum = '0;
        step(12);

        // Reset mid-debounce with an unread key pending
        wait_row_entry(4'b0100);
        colum = 3'b001;
        step(5);
        check("pre_reset_valid", 32'(key_valid), 32'h1);
        reset = 1'b1;
        colum = '0;
        step(1);
        reset = 1'b0;
        check("rst_scan", 32'(scan), 32'h1);
        check("rst_keycode", 32'(keycode), 32'h0);
        check("rst_flags", 32'({key_valid, key_held, multi, overrun}), 32'h0);

        // Enable freeze, then reset while frozen mid-count
        enable = 1'b0;
        step(50);
        check("freeze_scan", 32'(scan), 32'h1);
        enable = 1'b1;
        step(2);
        enable = 1'b0;
        step(30);
        check("freeze2_scan", 32'(scan), 32'h1);
        reset = 1'b1;
        step(1);
        reset  = 1'b0;
        enable = 1'b1;
        step(3);
        check("prescaler_reset", 32'(scan), 32'h1);
        step(1);
        check("prescaler_advance", 32'(scan), 32'b0010);

        // Ack while prescaler is stopped: row 3 c=1 -> keycode 7
        wait_row_entry(4'b1000);
        colum = 3'b010;
        push(4'd7, 1'b0);
        step(12);
        check("en_pub", 32'({key_valid, keycode}), 32'b1_0111);
        enable  = 1'b0;
        key_ack = 1'b1;
        step(1);
        key_ack = 1'b0;
        check("ack_while_disabled", 32'(key_valid), 32'h0);
        colum  = '0;
        enable = 1'b1;
        step(24);
        check("final_held", 32'(key_held), 32'h0);
        check("scoreboard_empty", 32'(exp_q.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/keypad_scanner_n.md
# keypad_scanner_n

Parametrised matrix-keypad scanner. Drives one-hot row strobes over a ROWS×COLS keypad and samples the column inputs at a divided scan rate. Debounces press and release, and publishes a keycode through a valid/ack handshake with overrun and multi-key detection. It sits between the keypad pins and the display/decoder logic and replaces the fixed 4×3, undebounced, free-running scanner.

## Interface
- ROWS, 4, number of row strobes (≥2)
- COLS, 3, number of column inputs (≥1)
- KEY_W, 4, keycode width; must satisfy 2^KEY_W ≥ ROWS*COLS
- TICK_DIV, 50000, fin cycles per scan tick (≥2)
- DEBOUNCE, 4, consecutive stable ticks required for press and for release (≥1)

- fin  in  1  system clock; all state on rising edge
- reset  in  1  synchronous, active-high reset
- enable  in  1  1 = prescaler runs; 0 = no ticks, FSM and scan frozen
- colum  in  COLS  column sense lines, active-high, asynchronous to fin
- key_ack  in  1  consumer acknowledges the current keycode (one-cycle pulse)
- scan  out  ROWS  one-hot row strobe
- keycode  out  KEY_W  last published key
- key_valid  out  1  keycode unread; held until key_ack
- key_held  out  1  debounced key currently down
- multi  out  1  more than one column active on the current row
- overrun  out  1  sticky; key published while previous was unread

## Operation
- colum passes a 2-flop synchroniser (colum_s). All decisions use colum_s sampled on tick cycles only.
- Prescaler: counts 0..TICK_DIV-1 while enable=1 and wraps. tick = 1 for one fin cycle when count = TICK_DIV-1. enable=0 holds the count.
- Row index r ∈ 0..ROWS-1; scan = 1<<r. Keycode = c*ROWS + r, zero-extended to KEY_W, where c is the active column index.
- FSM states and transitions (evaluated on tick):
  - SCAN, colum_s=0: multi←0, r←(r+1) mod ROWS.
  - SCAN, colum_s one-hot: capture c, deb_cnt←1, multi←0, go DEBOUNCE. r holds.
  - SCAN, colum_s ≥2 bits set: multi←1. r holds, stay SCAN.
  - DEBOUNCE, colum_s = captured one-hot: deb_cnt++. On reaching DEBOUNCE, publish and go HELD.
  - DEBOUNCE, any other value: return to SCAN. r holds; no publication.
  - HELD: key_held=1. colum_s=0 increments rel_cnt; nonzero clears rel_cnt. When rel_cnt reaches DEBOUNCE: key_held←0, r←(r+1) mod ROWS, go SCAN.
- With DEBOUNCE=1, publication occurs on the capture tick: SCAN→HELD directly.
- Publish: keycode←code; key_valid←1. If key_valid was already 1 and key_ack is not asserted this cycle, overrun←1.
- key_ack: key_valid←0 and overrun←0 on the next edge.
- Publish and key_ack in the same cycle: publish wins (key_valid stays 1, new keycode), overrun not set.
- key_ack while key_valid=0: no effect.
- reset (synchronous, any state, mid-debounce included): state SCAN, r=0, prescaler=0, deb_cnt=rel_cnt=0.

## Timing
- Reset values: scan=1 (row 0), keycode=0, key_valid=0, key_held=0, multi=0, overrun=0.
- Row advance: scan changes on the fin edge ending the tick cycle. Dwell per row is TICK_DIV fin cycles.
- Press latency: colum must be stable for ≥2 fin cycles before the capture tick. key_valid and key_held rise on the edge ending tick number DEBOUNCE-1 after the capture tick, i.e. (DEBOUNCE-1)*TICK_DIV fin cycles after capture.
- Release latency: key_held falls on the edge ending the DEBOUNCE-th consecutive zero tick.
- key_valid falls one fin cycle after the key_ack cycle, independent of enable and tick.
- Counters saturate logically; deb_cnt and rel_cnt widths are ≥ clog2(DEBOUNCE+1).

## Test plan
Bench parameters: ROWS=4, COLS=3, TICK_DIV=4, DEBOUNCE=3.
- Idle, no keys: scan sequences 0001→0010→0100→1000→0001, advancing every 4 fin cycles; all flags stay 0.
- Hold colum=3'b010 while scan=0100: scan freezes; key_valid=1 with keycode=6 (c=1, r=2) 8 fin cycles after capture; key_held=1. Release for 3 ticks: key_held=0 and scan advances to 1000.
- Bounce: colum=010 for 1 tick, then 000, then stable. The bounce produces no publication; key_valid only after 3 stable ticks.
- colum=3'b101 on a row: multi=1, scan frozen, no key_valid. Clear colum: multi=0 and scan resumes.
- Two presses without ack: the second publish sets overrun=1 and keycode shows the second key. key_ack clears key_valid and overrun. Publish coincident with key_ack: key_valid stays 1 and overrun stays 0.
- Assert reset mid-DEBOUNCE and with enable=0 freeze: next edge gives scan=0001 with all outputs at reset values. With enable=0, scan holds for >10 TICK_DIV periods.
